// File: rtl/sync_fifo_pkg.sv
// Shared sizing defaults for the sync_fifo slice.
package sync_fifo_pkg;

  // Default geometry: 16 entries of 32 bits, 4-bit pointers.
  localparam int C_DEF_P_N   = 4;
  localparam int C_DEF_WIDTH = 32;
  localparam int C_DEF_DEPTH = 16;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port register array: synchronous write port, read data registered
// on the read enable and held otherwise.
module sync_fifo_mem import sync_fifo_pkg::*; #(
  parameter int P_N     = C_DEF_P_N,
  parameter int F_WIDTH = C_DEF_WIDTH,
  parameter int F_DEPTH = C_DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [P_N-1:0]     i_wr_addr,
  input  logic [F_WIDTH-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [P_N-1:0]     i_rd_addr,
  output logic [F_WIDTH-1:0] o_rd_data
);

  logic [F_WIDTH-1:0] r_mem [F_DEPTH];
  logic [F_WIDTH-1:0] r_rd_data;

  // Storage write; the array is never cleared, only its pointers are.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy reporting.
//
// Request semantics: wr_en/rd_en are one-cycle requests sampled at the rising
// edge. A write is accepted only when not full, a read only when not empty;
// rejected requests are silently dropped. Full+both accepts only the read,
// empty+both accepts only the write (no bypass to rd_data). All flags and
// counts come straight from the count register, so there is no combinational
// path from the enables to them.
module sync_fifo import sync_fifo_pkg::*; #(
  parameter int P_N     = C_DEF_P_N,
  parameter int F_WIDTH = C_DEF_WIDTH,
  parameter int F_DEPTH = C_DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [F_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  output logic [F_WIDTH-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [P_N:0]       room_avail,
  output logic [P_N:0]       data_avail
);

  localparam logic [P_N:0] L_DEPTH = (P_N + 1)'(F_DEPTH);

  logic [P_N-1:0] r_wr_ptr;
  logic [P_N-1:0] r_rd_ptr;
  logic [P_N:0]   r_count;
  logic           w_wr_accept;
  logic           w_rd_accept;
  logic           w_full;
  logic           w_empty;

  assign w_full      = (r_count == L_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = wr_en && !w_full;
  assign w_rd_accept = rd_en && !w_empty;

  // Pointers advance on accepted accesses and wrap modulo F_DEPTH by width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .P_N     (P_N),
    .F_WIDTH (F_WIDTH),
    .F_DEPTH (F_DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_accept),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data)
  );

  assign full       = w_full;
  assign empty      = w_empty;
  assign data_avail = r_count;
  assign room_avail = L_DEPTH - r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int PN    = 4;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          full;
  logic          empty;
  logic [PN:0]   room_avail;
  logic [PN:0]   data_avail;

  sync_fifo #(.P_N(PN), .F_WIDTH(W), .F_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .room_avail (room_avail),
    .data_avail (data_avail)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored words in order, plus the expected read register
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rd_data"},    64'(rd_data),    64'(exp_rd));
    check({tag, ".data_avail"}, 64'(data_avail), 64'(exp_q.size()));
    check({tag, ".room_avail"}, 64'(room_avail), 64'(DEPTH - exp_q.size()));
    check({tag, ".full"},       64'(full),       64'(exp_q.size() == DEPTH));
    check({tag, ".empty"},      64'(empty),      64'(exp_q.size() == 0));
  endtask

  // One clock cycle of requests; the model decides acceptance from the
  // occupancy before the edge, then outputs are compared after the edge.
  task automatic drive(input logic we, input logic [W-1:0] wd, input logic re);
    bit acc_w;
    bit acc_r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    acc_w = we && (exp_q.size() < DEPTH);
    acc_r = re && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (acc_r) exp_rd = exp_q.pop_front();
    if (acc_w) exp_q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rd = '0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] first;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_state("reset");

    // Write-then-read, 30 times, wrapping the pointers
    for (int i = 0; i < 30; i++) begin
      w = $urandom;
      drive(1'b1, w, 1'b0);
      check_state("rw_wr");
      drive(1'b0, '0, 1'b1);
      check("rw_word", 64'(rd_data), 64'(w));
      check_state("rw_rd");
    end

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      w = ~(i + 1);
      drive(1'b1, w, 1'b0);
    end
    check_state("filled");
    check("fill_full", 64'(full), 64'd1);
    drive(1'b1, 32'h12345678, 1'b0);
    check_state("overflow");
    for (int i = 0; i < DEPTH; i++) begin
      w = ~(i + 1);
      drive(1'b0, '0, 1'b1);
      check("drain_word", 64'(rd_data), 64'(w));
    end
    check_state("drained");
    check("drain_empty", 64'(empty), 64'd1);

    // Underflow: read while empty holds rd_data and count
    w = rd_data;
    drive(1'b0, '0, 1'b1);
    check("underflow_hold", 64'(rd_data), 64'(w));
    check_state("underflow");

    // Simultaneous at count 5
    first = $urandom;
    drive(1'b1, first, 1'b0);
    for (int i = 1; i < 5; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b1, $urandom, 1'b1);
    check("both5_count", 64'(data_avail), 64'd5);
    check("both5_oldest", 64'(rd_data), 64'(first));
    check_state("both5");
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1);

    // Simultaneous when full: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0);
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    check("bothfull_count", 64'(data_avail), 64'd15);
    check_state("bothfull");
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, '0, 1'b1);
      check_state("bothfull_drain");
    end

    // Simultaneous when empty: write only, no bypass
    w = rd_data;
    drive(1'b1, 32'hA5A5A5A5, 1'b1);
    check("bothempty_nobypass", 64'(rd_data), 64'(w));
    check_state("bothempty");
    drive(1'b0, '0, 1'b1);
    check_state("bothempty_rd");

    // Mid-operation asynchronous reset at count 7
    for (int i = 0; i < 7; i++) drive(1'b1, $urandom, 1'b0);
    check("pre_rst_count", 64'(data_avail), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w = $urandom;
    drive(1'b1, w, 1'b0);
    check_state("post_rst_wr");
    drive(1'b0, '0, 1'b1);
    check("post_rst_word", 64'(rd_data), 64'(w));
    check_state("post_rst_rd");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised first-in-first-out buffer with registered read data and occupancy reporting. It decouples a producer and a consumer inside one clock domain. It reports `full`/`empty` flags plus the free-slot count and the stored-word count, so upstream logic can throttle and downstream logic can burst.

## Interface
Parameters:
- `P_N`, default 4: pointer width; `F_DEPTH` must equal 2**`P_N`.
- `F_WIDTH`, default 32: data word width in bits.
- `F_DEPTH`, default 16: number of storage entries.

Ports:
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: write request, sampled at rising edge.
- `wr_data`, input, `F_WIDTH`: word to write.
- `rd_en`, input, 1: read request, sampled at rising edge.
- `rd_data`, output, `F_WIDTH`: registered read word.
- `full`, output, 1: high when `F_DEPTH` words are stored.
- `empty`, output, 1: high when 0 words are stored.
- `room_avail`, output, `P_N`+1: free entries, range 0..`F_DEPTH`.
- `data_avail`, output, `P_N`+1: stored entries, range 0..`F_DEPTH`.

## Operation
- Storage: `F_DEPTH` × `F_WIDTH` array. Write pointer and read pointer are each `P_N` bits and wrap modulo `F_DEPTH` naturally. Occupancy count is `P_N`+1 bits.
- Accepted write: `wr_en` && !`full`. At the edge, store `wr_data` at the write pointer and increment the write pointer.
- Accepted read: `rd_en` && !`empty`. At the edge, load `rd_data` from the read pointer and increment the read pointer.
- Rejected requests have no effect:
  - write while `full`: data dropped, no pointer or count change;
  - read while `empty`: `rd_data` holds, no pointer or count change.
- Count update:
  - accepted write only: +1;
  - accepted read only: −1;
  - both accepted, or neither: unchanged.
- Simultaneous requests:
  - full with both `wr_en` and `rd_en` asserted: only the read is accepted; the write is dropped.
  - empty with both asserted: only the write is accepted; no bypass to `rd_data`.
- Outputs derive from the count register:
  - `data_avail` = count;
  - `room_avail` = `F_DEPTH` − count;
  - `full` = (count == `F_DEPTH`);
  - `empty` = (count == 0).
- `rd_data` holds its last value until the next accepted read.
- Order: strict FIFO order is preserved across any number of pointer wraps.

## Timing
- Reset (`rst_n` low, asynchronous, effective immediately, including mid-operation):
  - pointers and count = 0;
  - `empty`=1, `full`=0;
  - `data_avail`=0, `room_avail`=`F_DEPTH`;
  - `rd_data`=0.
  - Array contents need not be cleared.
- Write latency: a word written at edge N is readable by a read request sampled at edge N+1. Flags and counts reflect the write after edge N.
- Read latency: 1 cycle. `rd_en` sampled at edge N puts data on `rd_data` just after edge N; the data stays stable until the next accepted read.
- Flags and counts are registered or derived from registers only. They have no combinational path from `wr_en`/`rd_en`.
- No handshake beyond the enables. The producer must honour `full` and the consumer must honour `empty`; the block itself guards against overflow and underflow.

## Structure
- No shared package is required; all sizing comes from parameters.
- One natural sub-module, `sync_fifo_mem`: a simple dual-port register array with a synchronous write port, and read data registered on the read enable.
- Pointer, count and flag logic live in `sync_fifo`.

## Test plan
- Reset: after reset release, check `empty`=1, `full`=0, `data_avail`=0, `room_avail`=16, `rd_data`=0.
- Read after write, 30 iterations: write a random word, then read it, each iteration. Check:
  - `rd_data` matches the word written in that iteration;
  - `empty` returns to 1 after each read;
  - the pointers wrap past 15 without error.
- Fill then drain:
  - Write words ~(i+1) for i=0..15: `full`=1, `data_avail`=16, `room_avail`=0.
  - A 17th write of 0x12345678 is ignored.
  - 16 reads return 0xFFFFFFFE, 0xFFFFFFFD … 0xFFFFFFEF in order, then `empty`=1.
- Underflow: read while empty. `rd_data` and count are unchanged.
- Simultaneous requests:
  - at count 5, `wr_en` and `rd_en` asserted together for one cycle: count stays 5, and the oldest word appears on `rd_data`;
  - when full, both asserted: count becomes 15, and the written word is dropped.
- Mid-operation reset: assert `rst_n` low at count 7. Flags and counts return to reset values immediately without waiting for a clock edge. Subsequent write and read operate normally.
